// File: rtl/logs_pkg.sv
// logs_pkg: shared definitions for the logs_seq note sequencer.
//   - Pattern entry field positions as functions of the NCO width N.
//     An entry is {rest, dur[2:0], freq[N-2:0]}, N+3 bits wide.
//   - FSM state encoding shared by the sequencer.
package logs_pkg;

    // Duration field width (beats - 1, so 1..8 beats per note).
    localparam int DUR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int rest_bit(input int n);
        return n + 2;
    endfunction

    function automatic int dur_msb(input int n);
        return n + 1;
    endfunction

    function automatic int dur_lsb(input int n);
        return n - 1;
    endfunction

    function automatic int freq_msb(input int n);
        return n - 2;
    endfunction

endpackage

// File: rtl/logs_tick_div.sv
// logs_tick_div: PRESCALE clock divider producing a registered one-cycle tick.
//   clk   : clock
//   reset : synchronous active-high reset
//   clr   : synchronous clear of the count (tick forced low)
//   en    : count enable
//   tick  : high for one cycle while the count sits at PRESCALE-1
// After a clear, the first tick appears PRESCALE cycles later, then every
// PRESCALE cycles while enabled. PRESCALE must be >= 2.
module logs_tick_div #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] count_reg;
    logic          tick_reg;

    // tick_reg is set on the edge that moves the count to PRESCALE-1, so it
    // is high exactly during the cycle the count equals PRESCALE-1.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (en) begin
            count_reg <= (count_reg == CW'(PRESCALE - 1)) ? '0 : count_reg + 1'b1;
            tick_reg  <= (count_reg == CW'(PRESCALE - 2));
        end else begin
            tick_reg  <= 1'b0;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/logs_seq.sv
// logs_seq: note sequencer feeding a square-wave NCO.
// Plays LEN programmable entries {rest, dur, freq} in order, once or looped.
//   clk      : clock
//   reset    : synchronous active-high reset
//   run      : 1 = play, 0 = stop
//   loop     : restart at entry 0 after the last entry
//   wr_en    : pattern write strobe (legal in any state)
//   wr_addr  : pattern address
//   wr_data  : {rest, dur[2:0], freq[N-2:0]}
//   step     : one-cycle strobe every PRESCALE clocks while playing
//   freq_out : NCO frequency word (0 during rests and when not playing)
//   gate     : 1 while a non-rest note plays
//   busy     : 1 while playing
//   done     : one-cycle pulse when a non-looped pattern finishes
// Note length is (dur+1)*TICKS_PER_BEAT*PRESCALE clocks.
module logs_seq
    import logs_pkg::*;
#(
    parameter int N              = 5,
    parameter int PRESCALE       = 4,
    parameter int TICKS_PER_BEAT = 16,
    parameter int LEN            = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    loop,
    input  logic                    wr_en,
    input  logic [$clog2(LEN)-1:0]  wr_addr,
    input  logic [N+2:0]            wr_data,
    output logic                    step,
    output logic [N-2:0]            freq_out,
    output logic                    gate,
    output logic                    busy,
    output logic                    done
);

    localparam int AW       = $clog2(LEN);
    localparam int EW       = N + 3;
    localparam int TW       = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
    localparam int REST_BIT = rest_bit(N);
    localparam int DUR_MSB  = dur_msb(N);
    localparam int DUR_LSB  = dur_lsb(N);
    localparam int FREQ_MSB = freq_msb(N);

    // Pattern register file; not cleared by reset.
    logic [EW-1:0] mem [LEN];

    state_t            state_reg, state_next;
    logic [AW-1:0]     addr_reg, addr_next;
    logic [TW-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [DUR_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [EW-1:0]     ent_reg, ent_next;
    logic              fetch;
    logic [AW-1:0]     fetch_addr;

    logic              step_w;
    logic              tick_last;
    logic              note_end;
    logic              play_next;

    logic              busy_reg, gate_reg, done_reg;
    logic [N-2:0]      freq_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Divider runs only while actually playing; any other state (or run
    // dropping) holds it cleared so the first step lands PRESCALE clocks
    // after the start and no stray step survives a stop.
    logs_tick_div #(
        .PRESCALE(PRESCALE)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (!(state_reg == PLAY && run)),
        .en    (state_reg == PLAY),
        .tick  (step_w)
    );

    assign tick_last = (tick_cnt_reg == TW'(TICKS_PER_BEAT - 1));
    assign note_end  = step_w && tick_last && (beat_cnt_reg == ent_reg[DUR_MSB:DUR_LSB]);

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        tick_cnt_next = tick_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        fetch         = 1'b0;
        fetch_addr    = addr_reg;
        case (state_reg)
            IDLE: begin
                if (run) begin
                    state_next    = PLAY;
                    addr_next     = '0;
                    tick_cnt_next = '0;
                    beat_cnt_next = '0;
                    fetch         = 1'b1;
                    fetch_addr    = '0;
                end
            end
            PLAY: begin
                // Stopping wins over a note end in the same cycle.
                if (!run) begin
                    state_next = IDLE;
                end else if (note_end) begin
                    tick_cnt_next = '0;
                    beat_cnt_next = '0;
                    if (addr_reg == AW'(LEN - 1) && !loop) begin
                        state_next = DONE;
                    end else begin
                        // LEN is a power of two, so LEN-1 + 1 wraps to 0.
                        addr_next  = addr_reg + 1'b1;
                        fetch      = 1'b1;
                        fetch_addr = addr_reg + 1'b1;
                    end
                end else if (step_w) begin
                    if (tick_last) begin
                        tick_cnt_next = '0;
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Entry is copied at note start; later writes only affect the next fetch.
        ent_next  = fetch ? mem[fetch_addr] : ent_reg;
        play_next = (state_next == PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            tick_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            ent_reg      <= '0;
            busy_reg     <= 1'b0;
            gate_reg     <= 1'b0;
            done_reg     <= 1'b0;
            freq_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            tick_cnt_reg <= tick_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            ent_reg      <= ent_next;
            busy_reg     <= play_next;
            gate_reg     <= play_next && !ent_next[REST_BIT];
            done_reg     <= (state_next == DONE);
            freq_reg     <= (play_next && !ent_next[REST_BIT]) ? ent_next[FREQ_MSB:0] : '0;
        end
    end

    assign step     = step_w;
    assign freq_out = freq_reg;
    assign gate     = gate_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_logs_seq.sv
// tb_logs_seq: directed bench for logs_seq with a timing-level reference model.
// The model tracks play mode, the current entry, clocks elapsed in the note
// and clocks since play start; one process compares every output each cycle.
module tb_logs_seq;

    localparam int N        = 5;
    localparam int PRESCALE = 4;
    localparam int TPB      = 2;
    localparam int LEN      = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       run     = 1'b0;
    logic       loop    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       step;
    logic [3:0] freq_out;
    logic       gate;
    logic       busy;
    logic       done;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_count = 0;
    int rel        = 0;

    always #5 clk = ~clk;

    logs_seq #(
        .N(N),
        .PRESCALE(PRESCALE),
        .TICKS_PER_BEAT(TPB),
        .LEN(LEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .loop     (loop),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .step     (step),
        .freq_out (freq_out),
        .gate     (gate),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t+%0d: got %0h, expected %0h", name, rel, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode;      // 0 idle, 1 play, 2 done
    logic [7:0] m_mem [LEN];
    logic [7:0] m_ent;
    int         m_idx;
    int         m_pos;       // 1-based clock within the current note
    int         m_elapsed;   // 1-based clock since play start
    bit         m_valid = 1'b0;

    function automatic int note_clocks(input logic [7:0] e);
        return (int'(e[6:4]) + 1) * TPB * PRESCALE;
    endfunction

    initial begin
        m_mode = 0;
        m_ent = '0;
        m_idx = 0;
        m_pos = 0;
        m_elapsed = 0;
        for (int i = 0; i < LEN; i++) m_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: if (run) begin
                        m_mode = 1;
                        m_idx = 0;
                        m_ent = m_mem[0];
                        m_pos = 1;
                        m_elapsed = 1;
                    end
                    1: if (!run) begin
                        m_mode = 0;
                    end else if (m_pos == note_clocks(m_ent)) begin
                        if (m_idx == LEN - 1 && !loop) begin
                            m_mode = 2;
                        end else begin
                            m_idx = (m_idx + 1) % LEN;
                            m_ent = m_mem[m_idx];
                            m_pos = 1;
                            m_elapsed++;
                        end
                    end else begin
                        m_pos++;
                        m_elapsed++;
                    end
                    default: m_mode = 0;
                endcase
            end
            // Writes land after the fetch of the same edge.
            if (wr_en) m_mem[wr_addr] = wr_data;
            m_valid = 1'b1;
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    initial begin
        logic       e_play;
        logic       e_sound;
        logic [3:0] e_freq;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_play  = (m_mode == 1);
                e_sound = e_play && !m_ent[7];
                e_freq  = e_sound ? m_ent[3:0] : 4'd0;
                check("busy", 32'(busy), 32'(e_play));
                check("gate", 32'(gate), 32'(e_sound));
                check("freq_out", 32'(freq_out), 32'(e_freq));
                check("step", 32'(step), 32'(e_play && (m_elapsed % PRESCALE == 0)));
                check("done", 32'(done), 32'(m_mode == 2));
                if (done === 1'b1) done_count++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic go_to(input int k);
        while (rel < k) tick();
    endtask

    // Raise run; the next edge is t, and on return we sit in cycle t+1.
    task automatic start(input logic lp);
        loop = lp;
        run  = 1'b1;
        rel  = 0;
        tick();
    endtask

    task automatic stop_and_settle();
        run = 1'b0;
        repeat (3) tick();
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    int d0;

    initial begin
        repeat (3) tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_freq", 32'(freq_out), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        reset = 1'b0;
        tick();

        // Pattern: note freq 5 for two beats, then three one-beat rests.
        write_entry(2'd0, 8'h15);
        for (int i = 1; i < LEN; i++) write_entry(2'(i), 8'h80);

        // Single pass, run held through the done pulse.
        d0 = done_count;
        start(1'b0);
        check("single_busy_t1", 32'(busy), 32'd1);
        check("single_freq_t1", 32'(freq_out), 32'd5);
        check("single_gate_t1", 32'(gate), 32'd1);
        go_to(3);  check("single_step_t3", 32'(step), 32'd0);
        go_to(4);  check("single_step_t4", 32'(step), 32'd1);
        go_to(16); check("single_freq_t16", 32'(freq_out), 32'd5);
        check("single_step_t16", 32'(step), 32'd1);
        go_to(17); check("single_freq_t17", 32'(freq_out), 32'd0);
        check("single_gate_t17", 32'(gate), 32'd0);
        go_to(40); check("single_done_t40", 32'(done), 32'd0);
        go_to(41); check("single_done_t41", 32'(done), 32'd1);
        check("single_busy_t41", 32'(busy), 32'd0);
        go_to(42); check("single_done_t42", 32'(done), 32'd0);
        go_to(43); check("single_replay_freq", 32'(freq_out), 32'd5);
        check("single_done_count", 32'(done_count - d0), 32'd1);
        $display("single pass: done pulses %0d, replay busy %0b", done_count - d0, busy);
        stop_and_settle();

        // Looped pass with entry 0 rewritten during its own note.
        d0 = done_count;
        start(1'b1);
        go_to(5);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h19;
        tick();
        wr_en = 1'b0;
        go_to(16); check("loop_freq_t16", 32'(freq_out), 32'd5);
        go_to(40); check("loop_step_t40", 32'(step), 32'd1);
        go_to(41); check("loop_freq_t41", 32'(freq_out), 32'd9);
        check("loop_busy_t41", 32'(busy), 32'd1);
        go_to(44); check("loop_step_t44", 32'(step), 32'd1);
        go_to(56); check("loop_freq_t56", 32'(freq_out), 32'd9);
        go_to(57); check("loop_freq_t57", 32'(freq_out), 32'd0);
        check("loop_no_done", 32'(done_count - d0), 32'd0);
        $display("loop pass: freq after wrap %0d, done pulses %0d", freq_out, done_count - d0);
        stop_and_settle();
        write_entry(2'd0, 8'h15);

        // Stop mid-note.
        d0 = done_count;
        start(1'b0);
        go_to(10);
        run = 1'b0;
        go_to(11); check("stop_busy_t11", 32'(busy), 32'd0);
        check("stop_gate_t11", 32'(gate), 32'd0);
        go_to(12); check("stop_step_t12", 32'(step), 32'd0);
        go_to(30); check("stop_no_done", 32'(done_count - d0), 32'd0);
        $display("stop: busy %0b after run drop, done pulses %0d", busy, done_count - d0);
        stop_and_settle();

        // run drops on the final step of the pattern.
        d0 = done_count;
        start(1'b0);
        go_to(40); check("race_step_t40", 32'(step), 32'd1);
        run = 1'b0;
        go_to(41); check("race_busy_t41", 32'(busy), 32'd0);
        check("race_done_t41", 32'(done), 32'd0);
        go_to(43); check("race_no_done", 32'(done_count - d0), 32'd0);
        start(1'b0);
        check("race_restart_freq", 32'(freq_out), 32'd5);
        $display("run drop on final step: done pulses %0d, restart freq %0d", done_count - d0, freq_out);
        stop_and_settle();

        // Reset mid-note with run held.
        start(1'b0);
        go_to(6);
        reset = 1'b1;
        go_to(7);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_freq", 32'(freq_out), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        go_to(8);  check("rst_restart_freq", 32'(freq_out), 32'd5);
        go_to(10); check("rst_step_t10", 32'(step), 32'd0);
        go_to(11); check("rst_step_t11", 32'(step), 32'd1);
        $display("reset mid-play: restart freq %0d, busy %0b", freq_out, busy);
        stop_and_settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
